// File: rtl/rca_adder_core.sv
// rca_adder_core: parameterised ripple-carry adder with one registered output stage.
//   {c_out, sum} = a + b + c_in. The result appears one clock after in_valid is
//   sampled high. While in_valid is low, sum/c_out hold and out_valid is 0.
//
// Parameters:
//   WIDTH     operand and sum width in bits (1..64)
//
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset, clears all outputs
//   in_valid  qualifies a, b, c_in for capture this cycle
//   a, b      operands (two's complement when ovf is used)
//   c_in      carry into bit 0
//   sum       registered sum bits
//   c_out     registered carry out of the MSB cell
//   out_valid high for one cycle per accepted input
//   ovf       registered signed overflow (only when RCA_ADDER_OVF_EN is defined)
//
// Optional feature macro: RCA_ADDER_OVF_EN adds the ovf output and its register.

module rca_adder_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef RCA_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] s_comb;
  logic             c_last;

  // Each cell owns its carry-in/carry-out so the chain is a set of distinct nets
  // rather than one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = c_in;
    end else begin : g_chain
      assign ci = g_fa[i-1].co;
    end

    assign s_comb[i] = a[i] ^ b[i] ^ ci;
    assign co        = (a[i] & b[i]) | (a[i] & ci) | (b[i] & ci);
  end

  assign c_last = g_fa[WIDTH-1].co;

`ifdef RCA_ADDER_OVF_EN
  logic c_prev;
  logic ovf_d, ovf_q;

  // Carry into the MSB cell; overflow is carry-in xor carry-out of that cell.
  assign c_prev = g_fa[WIDTH-1].ci;
`endif

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = in_valid;
`ifdef RCA_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      sum_d   = s_comb;
      c_out_d = c_last;
`ifdef RCA_ADDER_OVF_EN
      ovf_d   = c_last ^ c_prev;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef RCA_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
`ifdef RCA_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;
`ifdef RCA_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_adder_core.sv
// Directed and exhaustive/random bench for rca_adder_core at WIDTH=4 and WIDTH=16.

module tb_rca_adder_core;

  logic clk;
  logic rst_n;

  logic       in_valid4;
  logic [3:0] a4, b4;
  logic       c_in4;
  logic [3:0] sum4;
  logic       c_out4;
  logic       out_valid4;
`ifdef RCA_ADDER_OVF_EN
  logic       ovf4;
  logic       ovf16;
`endif

  logic        in_valid16;
  logic [15:0] a16, b16;
  logic        c_in16;
  logic [15:0] sum16;
  logic        c_out16;
  logic        out_valid16;

  int checks = 0;
  int errors = 0;

  rca_adder_core #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .a        (a4),
    .b        (b4),
    .c_in     (c_in4),
    .sum      (sum4),
    .c_out    (c_out4),
`ifdef RCA_ADDER_OVF_EN
    .ovf      (ovf4),
`endif
    .out_valid(out_valid4)
  );

  rca_adder_core #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid16),
    .a        (a16),
    .b        (b16),
    .c_in     (c_in16),
    .sum      (sum16),
    .c_out    (c_out16),
`ifdef RCA_ADDER_OVF_EN
    .ovf      (ovf16),
`endif
    .out_valid(out_valid16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check dut4 outputs: {c_out, sum}, out_valid and (if present) ovf.
  task automatic chk4(input string tag, input logic [4:0] exp_res, input logic exp_vld,
                      input logic exp_ovf);
    chk({tag, "_res"}, 17'({c_out4, sum4}), 17'(exp_res));
    chk({tag, "_vld"}, 17'(out_valid4), 17'(exp_vld));
`ifdef RCA_ADDER_OVF_EN
    chk({tag, "_ovf"}, 17'(ovf4), 17'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected x ovf expectation in %s", tag);
`endif
  endtask

  task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic vv);
    a4        = va;
    b4        = vb;
    c_in4     = vc;
    in_valid4 = vv;
  endtask

  function automatic logic ovf_of4(input logic [3:0] va, input logic [3:0] vb,
                                   input logic [3:0] vs);
    return (va[3] == vb[3]) && (vs[3] != va[3]);
  endfunction

  initial begin
    logic [4:0]  exp5;
    logic [16:0] exp17;

    rst_n = 1'b1;
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
    in_valid16 = 1'b0;
    a16 = '0;
    b16 = '0;
    c_in16 = 1'b0;

    // Reset asserted between edges takes effect immediately.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk4("rst_async", 5'h00, 1'b0, 1'b0);
    chk("rst_async16", 17'({c_out16, sum16, out_valid16}), 17'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk4("rst_hold", 5'h00, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors back-to-back, one per clock.
    drive4(4'b0110, 4'b1100, 1'b0, 1'b1);
    @(posedge clk); #1; chk4("v0110_1100", 5'b1_0010, 1'b1, 1'b0);
    @(negedge clk); drive4(4'b1110, 4'b1000, 1'b0, 1'b1);
    @(posedge clk); #1; chk4("v1110_1000", 5'b1_0110, 1'b1, 1'b1);
    @(negedge clk); drive4(4'b0111, 4'b1110, 1'b0, 1'b1);
    @(posedge clk); #1; chk4("v0111_1110", 5'b1_0101, 1'b1, 1'b0);
    @(negedge clk); drive4(4'b0010, 4'b1001, 1'b0, 1'b1);
    @(posedge clk); #1; chk4("v0010_1001", 5'b0_1011, 1'b1, 1'b0);

    // Full carry ripple.
    @(negedge clk); drive4(4'b1111, 4'b0000, 1'b1, 1'b1);
    @(posedge clk); #1; chk4("wrap", 5'b1_0000, 1'b1, 1'b0);
    @(negedge clk); drive4(4'b1111, 4'b1111, 1'b1, 1'b1);
    @(posedge clk); #1; chk4("fullrange", 5'b1_1111, 1'b1, 1'b0);

    // Hold while in_valid is low.
    @(negedge clk); drive4(4'b0011, 4'b0001, 1'b0, 1'b1);
    @(posedge clk); #1; chk4("hold_cap", 5'b0_0100, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      drive4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1; chk4("hold", 5'b0_0100, 1'b0, 1'b0);
    end

    // Reset mid-stream discards the in-flight result.
    @(negedge clk); drive4(4'b0101, 4'b0101, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1; chk4("rst_mid", 5'h00, 1'b0, 1'b0);
    @(posedge clk); #1; chk4("rst_mid_edge", 5'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive4(4'b0101, 4'b0101, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1; chk4("rst_mid_release", 5'h00, 1'b0, 1'b0);

    // Exhaustive WIDTH=4, back-to-back.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      drive4(i[3:0], i[7:4], i[8], 1'b1);
      exp5 = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0, i[8]};
      @(posedge clk); #1;
      chk4("exh", exp5, 1'b1, ovf_of4(i[3:0], i[7:4], exp5[3:0]));
    end
    @(negedge clk); in_valid4 = 1'b0;

    // Random WIDTH=16, back-to-back.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c_in16 = 1'($urandom);
      if (i == 0) begin
        a16 = 16'hffff;
        b16 = 16'h0000;
        c_in16 = 1'b1;
      end
      in_valid16 = 1'b1;
      exp17 = {1'b0, a16} + {1'b0, b16} + {16'b0, c_in16};
      @(posedge clk); #1;
      chk("rnd16_res", 17'({c_out16, sum16}), exp17);
      chk("rnd16_vld", 17'(out_valid16), 17'h1);
`ifdef RCA_ADDER_OVF_EN
      chk("rnd16_ovf", 17'(ovf16),
          17'((a16[15] == b16[15]) && (exp17[15] != a16[15])));
`endif
    end
    @(negedge clk); in_valid16 = 1'b0;
    @(posedge clk); #1;
    chk("rnd16_vld_drop", 17'(out_valid16), 17'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
